// File: rtl/kmap_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// kmap_sweep_ctrl
//   Clocked sequencer that walks a combinational K-map function block through
//   every input combination of an n-variable function (2 <= n <= NVAR). It
//   samples F once per minterm, builds the captured minterm mask, compares it
//   bit by bit against an expected mask, and reports pass/fail, the number of
//   mismatching minterms and the index of the first mismatch.
//
//   Parameters
//     NVAR    maximum variable count (fn_in width; masks are 2**NVAR bits)
//     SETTLE  wait cycles after fn_in changes before F is sampled (0 allowed)
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     start      in   launch a sweep (accepted in IDLE or DONE)
//     nvar       in   variable count, clamped to 2..NVAR, latched at accept
//     exp_mask   in   expected minterm mask, latched at accept
//     fn_in      out  input vector to the function block (A is bit n-1)
//     fn_out     in   function block output F
//     busy       out  sweep in progress
//     done       out  one-cycle completion pulse
//     pass       out  captured mask equals expected mask over 2**n bits
//     mask       out  captured mask, bit i = F at fn_in = i
//     err_cnt    out  number of mismatching minterms
//     first_fail out  index of the first mismatching minterm
//
//   Build option
//     KMAP_SWEEP_STOP_ON_FAIL_EN : when defined, the sweep ends at the first
//     mismatching minterm (err_cnt is then at most 1 and unvisited mask bits
//     stay 0). When undefined, every sweep visits all 2**n minterms.
// ---------------------------------------------------------------------------
module kmap_sweep_ctrl #(
  parameter int NVAR   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             nvar,
  input  logic [(1<<NVAR)-1:0]   exp_mask,
  output logic [NVAR-1:0]        fn_in,
  input  logic                   fn_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<NVAR)-1:0]   mask,
  output logic [NVAR:0]          err_cnt,
  output logic [NVAR-1:0]        first_fail
);

  localparam int MW = 1 << NVAR;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [2:0]    NMAX        = 3'(NVAR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With no settle time the first minterm is sampled in the cycle after accept.
  localparam state_t FIRST_ST = (SETTLE > 0) ? WAIT : SAMPLE;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [NVAR-1:0]   idx_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        n_r;
  logic [MW-1:0]     exp_r;
  logic [MW-1:0]     mask_r;
  logic [NVAR:0]     err_r;
  logic [NVAR-1:0]   ff_r;
  logic              pass_r;
  logic              done_r;
  logic              busy_r;

  logic              accept_s;
  logic              miss_s;
  logic              stop_s;
  logic              last_s;
  logic [NVAR:0]     last_idx_s;

  // Clamp the requested variable count into the supported 2..NVAR range.
  function automatic logic [2:0] clamp_n(input logic [2:0] v);
    if (v < 3'd2) begin
      return 3'd2;
    end else if (v > NMAX) begin
      return NMAX;
    end else begin
      return v;
    end
  endfunction

  assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_idx_s = ((NVAR+1)'(1) << n_r) - (NVAR+1)'(1);
  assign last_s     = ({1'b0, idx_r} == last_idx_s);

  // Mismatch detection for the minterm currently being sampled.
  always_comb begin
    miss_s = 1'b0;
    if (state_r == SAMPLE) begin
      miss_s = (fn_out != exp_r[idx_r]);
    end else begin
      miss_s = 1'b0;
    end
  end

`ifdef KMAP_SWEEP_STOP_ON_FAIL_EN
  // Any mismatch is necessarily the first one, since the sweep ends on it.
  assign stop_s = miss_s;
`else
  assign stop_s = 1'b0;
`endif

  // Next-state logic of the sweep sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = FIRST_ST;
        else          state_nxt_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == SETTLE_LAST) state_nxt_s = SAMPLE;
        else                      state_nxt_s = WAIT;
      end
      SAMPLE: begin
        if (last_s || stop_s) state_nxt_s = DONE;
        else                  state_nxt_s = FIRST_ST;
      end
      DONE: begin
        if (accept_s) state_nxt_s = FIRST_ST;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Sweep datapath: latched configuration, minterm index, settle counter and
  // the captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r    <= 3'd0;
      exp_r  <= '0;
      idx_r  <= '0;
      cnt_r  <= '0;
      mask_r <= '0;
      err_r  <= '0;
      ff_r   <= '0;
      pass_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            n_r    <= clamp_n(nvar);
            exp_r  <= exp_mask;
            idx_r  <= '0;
            cnt_r  <= '0;
            mask_r <= '0;
            err_r  <= '0;
            ff_r   <= '0;
            pass_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == SETTLE_LAST) cnt_r <= '0;
          else                      cnt_r <= cnt_r + CW'(1);
        end
        SAMPLE: begin
          mask_r[idx_r] <= fn_out;
          if (miss_s) begin
            err_r <= err_r + (NVAR+1)'(1);
            if (err_r == '0) ff_r <= idx_r;
          end
          if (state_nxt_s == DONE) begin
            // fn_in returns to 0 for DONE; pass reflects the final count.
            idx_r  <= '0;
            pass_r <= (err_r == '0) && !miss_s;
          end else begin
            idx_r  <= idx_r + NVAR'(1);
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == DONE);
      busy_r <= (state_nxt_s == WAIT) || (state_nxt_s == SAMPLE);
    end
  end

  assign fn_in      = idx_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign mask       = mask_r;
  assign err_cnt    = err_r;
  assign first_fail = ff_r;

endmodule
